ldreg_fifo: RTL and testbench

//  Parametrised successor to the fixed 32-bit load-enable register (fdsyncr32).

---
 rtl/ldreg_pkg.sv | 17 +
 rtl/ldreg_mem.sv | 23 ++
 rtl/ldreg_fifo.sv | 118 +++++++++++
 tb/tb_ldreg_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ldreg_pkg.sv
// Shared types and helpers for the load-enable register FIFO (ldreg_fifo).
package ldreg_pkg;

  localparam int BYTE = 8;

  typedef struct packed {
    logic valid;
    logic full;
    logic ovf;
    logic unf;
  } status_t;

  function automatic int clog2_p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ldreg_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module ldreg_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset so it maps onto distributed RAM; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/ldreg_fifo.sv
// FWFT load-register FIFO with byte-enable merge against the last pushed word,
// registered status counts and sticky overflow/underflow flags.
module ldreg_fifo
  import ldreg_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int HOLD_LAST = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              d,
  input  logic [WIDTH/BYTE-1:0]         be,
  input  logic                          ld,
  input  logic                          rd,
  input  logic                          clr,
  output logic [WIDTH-1:0]              q,
  output logic                          valid,
  output logic                          full,
  output logic [clog2_p1(DEPTH)-1:0]    count,
  output logic                          ovf,
  output logic                          unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = clog2_p1(DEPTH);
  localparam int NB = WIDTH / BYTE;

  typedef struct packed {
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
  } state_t;

  state_t           r_state, w_state_nxt;
  status_t          r_status, w_status_nxt;
  logic [WIDTH-1:0] r_last_pushed, r_last_popped;
  logic [WIDTH-1:0] w_merged, w_head_data;
  logic             w_push, w_pop;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign w_pop  = rd & r_status.valid;
  assign w_push = ld & (~r_status.full | w_pop);

  // NOTE: combinational blocks use blocking assignments and default every output first, so no latch is inferred.
  always_comb begin
    w_merged = r_last_pushed;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) w_merged[i*BYTE +: BYTE] = d[i*BYTE +: BYTE];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    casez ({clr, w_push, w_pop})
      3'b1??: w_state_nxt = '0;
      3'b011: begin
        w_state_nxt.head = r_state.head + AW'(1);
        w_state_nxt.tail = r_state.tail + AW'(1);
      end
      3'b010: begin
        w_state_nxt.tail  = r_state.tail + AW'(1);
        w_state_nxt.count = r_state.count + CW'(1);
      end
      3'b001: begin
        w_state_nxt.head  = r_state.head + AW'(1);
        w_state_nxt.count = r_state.count - CW'(1);
      end
      default: ;
    endcase

    w_status_nxt.valid = (w_state_nxt.count != '0);
    w_status_nxt.full  = (w_state_nxt.count == CW'(DEPTH));
    w_status_nxt.ovf   = ~clr & (r_status.ovf | (ld & r_status.full & ~rd));
    w_status_nxt.unf   = ~clr & (r_status.unf | (rd & ~r_status.valid));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= '0;
      r_status      <= '0;
      r_last_pushed <= '0;
      r_last_popped <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
      if (clr) begin
        r_last_pushed <= '0;
        r_last_popped <= '0;
      end else begin
        if (w_push) r_last_pushed <= w_merged;
        if (w_pop)  r_last_popped <= w_head_data;
      end
    end
  end

  ldreg_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push & ~clr),
    .wr_addr (r_state.tail),
    .wr_data (w_merged),
    .rd_addr (r_state.head),
    .rd_data (w_head_data)
  );

  assign q     = r_status.valid ? w_head_data
               : ((HOLD_LAST != 0) ? r_last_popped : '0);
  assign valid = r_status.valid;
  assign full  = r_status.full;
  assign count = r_state.count;
  assign ovf   = r_status.ovf;
  assign unf   = r_status.unf;

endmodule

// File: tb/tb_ldreg_fifo.sv
// Directed bench for ldreg_fifo (WIDTH=32, DEPTH=4, HOLD_LAST=1) with hand-computed expectations.
module tb_ldreg_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] d;
  logic [3:0]  be;
  logic        ld, rd, clr;
  logic [31:0] q;
  logic        valid, full, ovf, unf;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  ldreg_fifo #(.WIDTH(32), .DEPTH(4), .HOLD_LAST(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .be    (be),
    .ld    (ld),
    .rd    (rd),
    .clr   (clr),
    .q     (q),
    .valid (valid),
    .full  (full),
    .count (count),
    .ovf   (ovf),
    .unf   (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic i_ld, input logic i_rd, input logic i_clr,
                      input logic [31:0] i_d, input logic [3:0] i_be);
    ld  = i_ld;
    rd  = i_rd;
    clr = i_clr;
    d   = i_d;
    be  = i_be;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic e_valid, input logic e_full,
                              input logic [2:0] e_count, input logic e_ovf, input logic e_unf);
    check({tag, ".valid"}, 32'(valid), 32'(e_valid));
    check({tag, ".full"},  32'(full),  32'(e_full));
    check({tag, ".count"}, 32'(count), 32'(e_count));
    check({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
    check({tag, ".unf"},   32'(unf),   32'(e_unf));
  endtask

  initial begin
    rst_n = 1'b0;
    ld = 1'b0; rd = 1'b0; clr = 1'b0; d = '0; be = '0;
    #12;
    check("rst.q", q, 32'h0);
    check_status("rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill: FWFT head appears the cycle after the first push.
    step(1, 0, 0, 32'h11111111, 4'hF);
    check("fill1.q", q, 32'h11111111);
    check_status("fill1", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1, 0, 0, 32'h22222222, 4'hF);
    step(1, 0, 0, 32'h33333333, 4'hF);
    step(1, 0, 0, 32'h44444444, 4'hF);
    check("fill4.q", q, 32'h11111111);
    check_status("fill4", 1'b1, 1'b1, 3'd4, 1'b0, 1'b0);

    // Push while full without pop: dropped, ovf sticky.
    step(1, 0, 0, 32'h55555555, 4'hF);
    check_status("ovf", 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    step(0, 0, 0, 32'h0, 4'h0);
    check("ovf_sticky", 32'(ovf), 32'd1);

    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d.q", i), q, {8{4'(i)}});
      step(0, 1, 0, 32'h0, 4'h0);
    end
    check("drained.q_hold", q, 32'h44444444);
    check_status("drained", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

    // Byte-enable merge against the last pushed word.
    step(1, 0, 0, 32'hAABBCCDD, 4'hF);
    step(1, 0, 0, 32'h11223344, 4'h5);
    check("merge.first", q, 32'hAABBCCDD);
    step(0, 1, 0, 32'h0, 4'h0);
    check("merge.second", q, 32'hAA22CC44);
    step(0, 1, 0, 32'h0, 4'h0);

    // Hold last popped word while empty; a pop on empty sets unf only.
    step(1, 0, 0, 32'hDEADBEEF, 4'hF);
    step(0, 1, 0, 32'h0, 4'h0);
    check("hold.q", q, 32'hDEADBEEF);
    check_status("hold", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    step(0, 1, 0, 32'h0, 4'h0);
    check("unf.q", q, 32'hDEADBEEF);
    check_status("unf", 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

    // clr flushes flags and the last_* registers.
    step(0, 0, 1, 32'h0, 4'h0);
    check("clr.q", q, 32'h0);
    check_status("clr", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Simultaneous push/pop on empty: push taken, pop flagged.
    step(1, 1, 0, 32'h0A0A0A0A, 4'hF);
    check("emptyldrd.q", q, 32'h0A0A0A0A);
    check_status("emptyldrd", 1'b1, 1'b0, 3'd1, 1'b0, 1'b1);
    step(0, 0, 1, 32'h0, 4'h0);

    // Full FIFO streaming: simultaneous ld/rd keeps count at DEPTH.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h100 + 32'(i), 4'hF);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("stream%0d.q", i), q, 32'h100 + 32'(i));
      step(1, 1, 0, 32'h104 + 32'(i), 4'hF);
      check($sformatf("stream%0d.count", i), 32'(count), 32'd4);
      check($sformatf("stream%0d.ovf", i), 32'(ovf), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sdrain%0d.q", i), q, 32'h108 + 32'(i));
      step(0, 1, 0, 32'h0, 4'h0);
    end
    check_status("sdrained", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // clr together with ld mid-stream (count = 2, unf set first).
    step(0, 1, 0, 32'h0, 4'h0);
    step(1, 0, 0, 32'h201, 4'hF);
    step(1, 0, 0, 32'h202, 4'hF);
    check_status("pre_clr", 1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
    step(1, 0, 1, 32'h999, 4'hF);
    check("clrld.q", q, 32'h0);
    check_status("clrld", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(0, 0, 0, 32'h0, 4'h0);
    check("clrld.count_after", 32'(count), 32'd0);
    step(1, 0, 0, 32'hFFFFFFFF, 4'h0);
    check("clr_lastpushed.q", q, 32'h0);
    check("clr_lastpushed.valid", 32'(valid), 32'd1);

    // Asynchronous reset between edges with count = 2.
    step(0, 1, 0, 32'h0, 4'h0);
    step(1, 0, 0, 32'h301, 4'hF);
    step(1, 1, 0, 32'h302, 4'hF);
    step(0, 1, 0, 32'h0, 4'h0);
    step(0, 1, 0, 32'h0, 4'h0);
    step(0, 1, 0, 32'h0, 4'h0);
    step(1, 0, 0, 32'h303, 4'hF);
    step(1, 0, 0, 32'h304, 4'hF);
    step(0, 0, 0, 32'h0, 4'h0);
    check_status("pre_arst", 1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
    check("pre_arst.q", q, 32'h303);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.q", q, 32'h0);
    check_status("arst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
